// File: rtl/gpio_exec_if.sv
// GPIO-side bundle for the BRAM->DSP->BRAM sequencer.
// The processor drives the instruction word; the sequencer returns strobes, latched fields and status.
interface gpio_exec_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      inst;
    logic             bram0_en;
    logic [4:0]       bram0_raddr;
    logic             bram1_en;
    logic [4:0]       bram1_raddr;
    logic             bram1_we;
    logic [4:0]       bram1_waddr;
    logic [4:0]       dsp_inmode;
    logic [6:0]       dsp_opmode;
    logic [3:0]       dsp_alumode;
    logic             dsp_ce;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cmd_count;

    modport master (
        output inst,
        input  bram0_en, bram0_raddr, bram1_en, bram1_raddr, bram1_we, bram1_waddr,
               dsp_inmode, dsp_opmode, dsp_alumode, dsp_ce, busy, done, cmd_count
    );

    modport slave (
        input  inst,
        output bram0_en, bram0_raddr, bram1_en, bram1_raddr, bram1_we, bram1_waddr,
               dsp_inmode, dsp_opmode, dsp_alumode, dsp_ce, busy, done, cmd_count
    );
endinterface

// File: rtl/gpio_exec_sequencer.sv
// Runs one BRAM read -> DSP -> BRAM write operation per rising edge of the GPIO execute bit.
//   state     | meaning
//   S_IDLE    | waiting for execute rising edge
//   S_RD      | one cycle of BRAM0/BRAM1 read enable
//   S_WAIT_RD | BRAM_RD_LAT cycles for read data
//   S_EXEC    | DSP_LAT cycles with dsp_ce high
//   S_WRITE   | single BRAM1 write strobe, command counted
//   S_DONE    | done high until execute is seen low
module gpio_exec_sequencer #(
    parameter int BRAM_RD_LAT = 1,
    parameter int DSP_LAT     = 3,
    parameter int CNT_W       = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    gpio_exec_if.slave bus
);
    localparam int MAX_LAT = (BRAM_RD_LAT > DSP_LAT) ? BRAM_RD_LAT : DSP_LAT;
    localparam int STG_W   = $clog2(MAX_LAT + 1);
    localparam logic [STG_W-1:0] RD_LOAD = STG_W'(BRAM_RD_LAT - 1);
    localparam logic [STG_W-1:0] EX_LOAD = STG_W'(DSP_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WAIT_RD, S_EXEC, S_WRITE, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [STG_W-1:0] stg_q, stg_d;
    logic             exec_q;
    logic             trigger;

    logic             rd_en_q, rd_en_d;
    logic             ce_q, ce_d;
    logic             we_q, we_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q;

    logic [4:0]       b0_raddr_q, b1_raddr_q, b1_waddr_q, inmode_q;
    logic [6:0]       opmode_q;
    logic [3:0]       alumode_q;

    assign trigger = (state_q == S_IDLE) && bus.inst[31] && !exec_q;

    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        case (state_q)
            S_IDLE:    if (trigger) state_d = S_RD;
            S_RD: begin
                state_d = S_WAIT_RD;
                stg_d   = RD_LOAD;
            end
            S_WAIT_RD: begin
                if (stg_q == '0) begin
                    state_d = S_EXEC;
                    stg_d   = EX_LOAD;
                end else begin
                    stg_d = stg_q - STG_W'(1);
                end
            end
            S_EXEC: begin
                if (stg_q == '0) state_d = S_WRITE;
                else             stg_d   = stg_q - STG_W'(1);
            end
            S_WRITE:   state_d = S_DONE;
            S_DONE:    if (!bus.inst[31]) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Strobes are registered from the next state so they line up exactly with the state they describe.
        rd_en_d = (state_d == S_RD);
        ce_d    = (state_d == S_EXEC);
        we_d    = (state_d == S_WRITE);
        busy_d  = (state_d == S_RD) || (state_d == S_WAIT_RD) ||
                  (state_d == S_EXEC) || (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            stg_q      <= '0;
            exec_q     <= 1'b1;
            rd_en_q    <= 1'b0;
            ce_q       <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            b0_raddr_q <= '0;
            b1_raddr_q <= '0;
            b1_waddr_q <= '0;
            inmode_q   <= '0;
            opmode_q   <= '0;
            alumode_q  <= '0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            exec_q  <= bus.inst[31];
            rd_en_q <= rd_en_d;
            ce_q    <= ce_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (we_d) cnt_q <= cnt_q + CNT_W'(1);
            if (trigger) begin
                b0_raddr_q <= bus.inst[4:0];
                b1_raddr_q <= bus.inst[9:5];
                b1_waddr_q <= bus.inst[14:10];
                inmode_q   <= bus.inst[19:15];
                opmode_q   <= bus.inst[26:20];
                alumode_q  <= bus.inst[30:27];
            end
        end
    end

    assign bus.bram0_en    = rd_en_q;
    assign bus.bram1_en    = rd_en_q;
    assign bus.bram0_raddr = b0_raddr_q;
    assign bus.bram1_raddr = b1_raddr_q;
    assign bus.bram1_we    = we_q;
    assign bus.bram1_waddr = b1_waddr_q;
    assign bus.dsp_inmode  = inmode_q;
    assign bus.dsp_opmode  = opmode_q;
    assign bus.dsp_alumode = alumode_q;
    assign bus.dsp_ce      = ce_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cmd_count   = cnt_q;
endmodule

// File: tb/tb_gpio_exec_sequencer.sv
// Directed bench: default-latency instance plus a BRAM_RD_LAT=2/DSP_LAT=1 instance with a 2-bit counter for wrap.
module tb_gpio_exec_sequencer;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    gpio_exec_if #(.CNT_W(16)) if_a ();
    gpio_exec_if #(.CNT_W(2))  if_b ();

    gpio_exec_sequencer #(.BRAM_RD_LAT(1), .DSP_LAT(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a)
    );
    gpio_exec_sequencer #(.BRAM_RD_LAT(2), .DSP_LAT(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {bram0_en, bram1_en, dsp_ce, bram1_we, busy, done} expected k cycles after the trigger edge
    function automatic logic [5:0] exp_strb(input int k, input int l, input int d);
        if (k == 1)         return 6'b110010;
        if (k <= 1 + l)     return 6'b000010;
        if (k <= 1 + l + d) return 6'b001010;
        if (k == 2 + l + d) return 6'b000110;
        return 6'b000001;
    endfunction

    function automatic logic [5:0] strb_a();
        return {if_a.bram0_en, if_a.bram1_en, if_a.dsp_ce, if_a.bram1_we, if_a.busy, if_a.done};
    endfunction

    function automatic logic [5:0] strb_b();
        return {if_b.bram0_en, if_b.bram1_en, if_b.dsp_ce, if_b.bram1_we, if_b.busy, if_b.done};
    endfunction

    initial begin
        rst_n     = 1'b0;
        if_a.inst = 32'h0;
        if_b.inst = 32'h0;
        #3;
        chk("reset_strobes", 32'(strb_a()), 32'h0);
        chk("reset_count", 32'(if_a.cmd_count), 32'h0);
        chk("reset_fields", {if_a.bram0_raddr, if_a.bram1_waddr, if_a.dsp_opmode}, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Basic operation
        if_a.inst = 32'h8AB1_8C43;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("basic_strb_k%0d", k), 32'(strb_a()), 32'(exp_strb(k, 1, 3)));
        end
        chk("basic_b0_raddr", 32'(if_a.bram0_raddr), 32'd3);
        chk("basic_b1_raddr", 32'(if_a.bram1_raddr), 32'd2);
        chk("basic_b1_waddr", 32'(if_a.bram1_waddr), 32'd3);
        chk("basic_inmode",   32'(if_a.dsp_inmode),  32'h03);
        chk("basic_opmode",   32'(if_a.dsp_opmode),  32'h2B);
        chk("basic_alumode",  32'(if_a.dsp_alumode), 32'h1);
        chk("basic_count",    32'(if_a.cmd_count),   32'd1);

        // Held execute: stays in DONE, no second write
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("held_strb_%0d", k), 32'(strb_a()), 32'b000001);
        end
        if_a.inst = 32'h0AB1_8C43;
        tick();
        chk("drop_done", 32'(if_a.done), 32'd0);
        chk("drop_count", 32'(if_a.cmd_count), 32'd1);

        // Second command with field changes during EXEC
        if_a.inst = 32'h8AB1_8C43;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("second_strb_k%0d", k), 32'(strb_a()), 32'(exp_strb(k, 1, 3)));
            if (k == 3) if_a.inst = 32'h8AB1_FFFF;
            if (k == 6) chk("second_waddr_at_write", 32'(if_a.bram1_waddr), 32'd3);
        end
        chk("second_b0_raddr", 32'(if_a.bram0_raddr), 32'd3);
        chk("second_count", 32'(if_a.cmd_count), 32'd2);

        // Mid-op reset during EXEC, execute held high across release
        if_a.inst = 32'h0000_0000;
        tick();
        if_a.inst = 32'h8000_0421;
        for (int k = 1; k <= 4; k++) tick();
        chk("pre_reset_strb", 32'(strb_a()), 32'(exp_strb(4, 1, 3)));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_strb", 32'(strb_a()), 32'h0);
        chk("async_reset_count", 32'(if_a.cmd_count), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("held_exec_no_trig_%0d", k), 32'(strb_a()), 32'h0);
        end
        chk("held_exec_fields", {if_a.bram0_raddr, if_a.bram1_raddr}, 32'h0);

        // Execute toggles 0->1: new command starts, latches fresh fields
        if_a.inst = 32'h0000_0421;
        tick();
        if_a.inst = 32'h8000_0421;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("post_reset_strb_k%0d", k), 32'(strb_a()), 32'(exp_strb(k, 1, 3)));
        end
        chk("post_reset_b1_raddr", 32'(if_a.bram1_raddr), 32'd1);
        chk("post_reset_b1_waddr", 32'(if_a.bram1_waddr), 32'd1);
        chk("post_reset_count", 32'(if_a.cmd_count), 32'd1);

        // Quick drop/raise from DONE: edge seen once back in IDLE
        if_a.inst = 32'h0000_0421;
        tick();
        if_a.inst = 32'h8000_0421;
        tick();
        chk("quick_retrig_rd", 32'(strb_a()), 32'b110010);
        if_a.inst = 32'h0000_0421;
        for (int k = 2; k <= 7; k++) tick();
        chk("quick_retrig_count", 32'(if_a.cmd_count), 32'd2);
        tick();
        chk("quick_exit_idle", 32'(strb_a()), 32'h0);

        // Sweep instance: L=2, D=1, 2-bit counter wraps on the 4th command
        for (int c = 1; c <= 5; c++) begin
            if_b.inst = 32'h8000_0000 | 32'(c);
            for (int k = 1; k <= 6; k++) begin
                tick();
                chk($sformatf("sweep_c%0d_k%0d", c, k), 32'(strb_b()), 32'(exp_strb(k, 2, 1)));
            end
            chk($sformatf("sweep_count_c%0d", c), 32'(if_b.cmd_count), 32'(c % 4));
            if_b.inst = 32'h0;
            tick();
        end
        chk("sweep_b0_raddr", 32'(if_b.bram0_raddr), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
